// File: rtl/enc_bus_pkg.sv
// Shared constants and FSM state type for the encoder bus reader.
package enc_bus_pkg;
  localparam int         N_CH_MAX        = 14;
  localparam logic [3:0] ADDR_SEQ        = 4'd0;
  localparam logic [3:0] ADDR_CNT_BASE   = 4'd1;
  localparam logic [3:0] ADDR_DELTA_BASE = 4'd8;

  typedef enum logic [2:0] {IDLE, START, SNAP, LOAD, HOLD} state_t;
endpackage

// File: rtl/enc_bus_reader_if.sv
// MCU parallel bus: chip select, read strobe, word address, read data and drive enable.
interface enc_bus_reader_if #(parameter int CNT_W = 16);
  logic             cs_n;
  logic             rd_n;
  logic [3:0]       addr;
  logic [CNT_W-1:0] data_out;
  logic             data_oe;

  modport master (output cs_n, rd_n, addr, input data_out, data_oe);
  modport slave  (input cs_n, rd_n, addr, output data_out, data_oe);
endinterface

// File: rtl/enc_bus_sync.sv
// Synchronizer for the async bus inputs plus rd_act edge detection.
// Chains reset to the "read active" level and the edge history to 1, so a bus
// held in a read across reset release never looks like a fresh read start.
module enc_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic [3:0] addr,
  output logic       rd_act,
  output logic       rd_rise,
  output logic       rd_fall,
  output logic [3:0] addr_s
);
  logic [SYNC_STAGES-1:0]      cs_pipe, rd_pipe;
  logic [SYNC_STAGES-1:0][3:0] addr_pipe;
  logic                        rd_act_d;

  // shift bus inputs through the synchronizer chain and remember last rd_act
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_pipe   <= '0;
      rd_pipe   <= '0;
      addr_pipe <= '0;
      rd_act_d  <= 1'b1;
    end else begin
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], cs_n};
      rd_pipe   <= {rd_pipe[SYNC_STAGES-2:0], rd_n};
      addr_pipe <= {addr_pipe[SYNC_STAGES-2:0], addr};
      rd_act_d  <= rd_act;
    end
  end

  assign rd_act  = ~cs_pipe[SYNC_STAGES-1] & ~rd_pipe[SYNC_STAGES-1];
  assign rd_rise = rd_act & ~rd_act_d;
  assign rd_fall = ~rd_act & rd_act_d;
  assign addr_s  = addr_pipe[SYNC_STAGES-1];
endmodule

// File: rtl/enc_bus_reader.sv
// Presents live encoder counts on the MCU bus. Address 0 snapshots all
// channels in one cycle and returns the new sequence number; 1..N_CH return
// the snapshot. Optional macro ENC_DELTA_EN adds per-channel deltas at 8+.
module enc_bus_reader
  import enc_bus_pkg::*;
#(
  parameter int N_CH        = 7,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  enc_bus_reader_if.slave       bus,
  input  logic [N_CH*CNT_W-1:0] cnt_flat,
  output logic [CNT_W-1:0]      snap_seq
);
  state_t                     state, nxt;
  logic                       rd_act, rd_rise, rd_fall;
  logic [3:0]                 addr_s, addr_q;
  logic [N_CH-1:0][CNT_W-1:0] snap;
`ifdef ENC_DELTA_EN
  logic [N_CH-1:0][CNT_W-1:0] prev;
`endif
  logic [CNT_W-1:0]           rd_word, data_q;
  logic                       oe_q, do_snap, do_load;

  enc_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs_n    (bus.cs_n),
    .rd_n    (bus.rd_n),
    .addr    (bus.addr),
    .rd_act  (rd_act),
    .rd_rise (rd_rise),
    .rd_fall (rd_fall),
    .addr_s  (addr_s)
  );

  // state register; address captured only on the read-start cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && rd_rise) addr_q <= addr_s;
    end
  end

  // next state; a strobe that already dropped in START was a glitch, abandon it
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (rd_rise) nxt = START;
      START:   if (!rd_act) nxt = IDLE;
               else if (addr_q == ADDR_SEQ) nxt = SNAP;
               else nxt = LOAD;
      SNAP:    nxt = LOAD;
      LOAD:    nxt = HOLD;
      HOLD:    if (rd_fall || !rd_act) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign do_snap = (state == START) && (nxt == SNAP);
  assign do_load = (state != LOAD) && (nxt == LOAD);

  // read map: sequence, snapshot counts, optional deltas, zero elsewhere
  always_comb begin
    rd_word = '0;
    if (addr_q == ADDR_SEQ) rd_word = snap_seq;
    for (int k = 0; k < N_CH; k++) begin
`ifdef ENC_DELTA_EN
      if (int'(addr_q) == int'(ADDR_DELTA_BASE) + k) rd_word = snap[k] - prev[k];
`endif
      if (int'(addr_q) == int'(ADDR_CNT_BASE) + k) rd_word = snap[k];
    end
  end

  // coherent snapshot of all channels in one cycle, sequence wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      snap_seq <= '0;
`ifdef ENC_DELTA_EN
      prev     <= '0;
`endif
    end else if (do_snap) begin
      snap     <= cnt_flat;
      snap_seq <= snap_seq + CNT_W'(1);
`ifdef ENC_DELTA_EN
      prev     <= snap;
`endif
    end
  end

  // registered read data (held after the read) and drive enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      if (do_load) data_q <= rd_word;
      oe_q <= (nxt == LOAD) || (nxt == HOLD);
    end
  end

  assign bus.data_out = data_q;
  assign bus.data_oe  = oe_q;
endmodule
